// File: rtl/ex_stage_if.sv
// ex_stage_if: operand bus from the ID/EX register and result bus towards EX/MEM, PC/IF and the controller.
interface ex_stage_if;
  logic [31:0] pc_i;
  logic [31:0] reg1_i;
  logic [31:0] reg2_i;
  logic [31:0] imm_i;
  logic [7:0]  aluop_i;
  logic [2:0]  alusel_i;
  logic [4:0]  wd_i;
  logic        wreg_i;
  logic [5:0]  stall;

  logic [4:0]  wd_o;
  logic        wreg_o;
  logic [31:0] wdata_o;
  logic [7:0]  aluop_o;
  logic [31:0] mem_addr_o;
  logic [31:0] reg2_o;
  logic        branch_flag_o;
  logic [31:0] branch_target_o;
  logic        exflush_o;
  logic        stallreq_o;

  modport master (
    output pc_i, reg1_i, reg2_i, imm_i, aluop_i, alusel_i, wd_i, wreg_i, stall,
    input  wd_o, wreg_o, wdata_o, aluop_o, mem_addr_o, reg2_o,
           branch_flag_o, branch_target_o, exflush_o, stallreq_o
  );

  modport slave (
    input  pc_i, reg1_i, reg2_i, imm_i, aluop_i, alusel_i, wd_i, wreg_i, stall,
    output wd_o, wreg_o, wdata_o, aluop_o, mem_addr_o, reg2_o,
           branch_flag_o, branch_target_o, exflush_o, stallreq_o
  );
endinterface

// File: rtl/ex_stage.sv
// ex_stage: combinational ALU, branch resolution and load/store address generation.
// `define MULDIV_EN adds an iterative multiply/divide unit that stalls the pipeline for 33 cycles per M op.
`ifndef EX_STAGE_DEFINES
`define EX_STAGE_DEFINES
`define Stop          1'b1
`define NoStop        1'b0
`define Inst_NOP      8'h00
`define EXE_ADD_OP    8'h01
`define EXE_SUB_OP    8'h02
`define EXE_SLL_OP    8'h03
`define EXE_SLT_OP    8'h04
`define EXE_SLTU_OP   8'h05
`define EXE_XOR_OP    8'h06
`define EXE_SRL_OP    8'h07
`define EXE_SRA_OP    8'h08
`define EXE_OR_OP     8'h09
`define EXE_AND_OP    8'h0A
`define EXE_LUI_OP    8'h0B
`define EXE_AUIPC_OP  8'h0C
`define EXE_JAL_OP    8'h10
`define EXE_JALR_OP   8'h11
`define EXE_BEQ_OP    8'h12
`define EXE_BNE_OP    8'h13
`define EXE_BLT_OP    8'h14
`define EXE_BGE_OP    8'h15
`define EXE_BLTU_OP   8'h16
`define EXE_BGEU_OP   8'h17
`define EXE_LB_OP     8'h20
`define EXE_LH_OP     8'h21
`define EXE_LW_OP     8'h22
`define EXE_LBU_OP    8'h23
`define EXE_LHU_OP    8'h24
`define EXE_SB_OP     8'h28
`define EXE_SH_OP     8'h29
`define EXE_SW_OP     8'h2A
`define EXE_RES_NOP       3'd0
`define EXE_RES_LOGIC     3'd1
`define EXE_RES_SHIFT     3'd2
`define EXE_RES_ARITH     3'd3
`define EXE_RES_JUMP      3'd4
`define EXE_RES_BRANCH    3'd5
`define EXE_RES_LOADSTORE 3'd6
`define EXE_RES_MUL       3'd7
`endif

module ex_stage (
  input  logic      clk,
  input  logic      rst,
  ex_stage_if.slave bus
);

  logic [31:0] a, b, pc, imm, a_imm, pc_imm, pc_4;
  logic [7:0]  op;
  logic        is_mop, is_jump, is_mem, br_take, br;
  logic [31:0] logic_res, shift_res, arith_res, sc_res, target, wdata;
  logic        wreg;
  logic        md_stall, md_done;
  logic [31:0] md_res;
  logic        unused_stall;

  assign a      = bus.reg1_i;
  assign b      = bus.reg2_i;
  assign pc     = bus.pc_i;
  assign imm    = bus.imm_i;
  assign op     = bus.aluop_i;
  assign a_imm  = a + imm;
  assign pc_imm = pc + imm;
  assign pc_4   = pc + 32'd4;
  // M-extension opcodes occupy 0x30..0x37
  assign is_mop = (op[7:3] == 5'b00110);
  assign unused_stall = ^bus.stall;

  always_comb begin
    logic_res = '0;
    shift_res = '0;
    arith_res = '0;
    br_take   = 1'b0;
    is_jump   = 1'b0;
    is_mem    = 1'b0;
    target    = pc_imm;
    case (op)
      `EXE_AND_OP:   logic_res = a & b;
      `EXE_OR_OP:    logic_res = a | b;
      `EXE_XOR_OP:   logic_res = a ^ b;
      `EXE_SLL_OP:   shift_res = a << b[4:0];
      `EXE_SRL_OP:   shift_res = a >> b[4:0];
      `EXE_SRA_OP:   shift_res = $signed(a) >>> b[4:0];
      `EXE_ADD_OP:   arith_res = a + b;
      `EXE_SUB_OP:   arith_res = a - b;
      `EXE_SLT_OP:   arith_res = {31'd0, $signed(a) < $signed(b)};
      `EXE_SLTU_OP:  arith_res = {31'd0, a < b};
      `EXE_LUI_OP:   arith_res = imm;
      `EXE_AUIPC_OP: arith_res = pc_imm;
      `EXE_JAL_OP:   is_jump = 1'b1;
      `EXE_JALR_OP: begin
        is_jump = 1'b1;
        target  = {a_imm[31:1], 1'b0};
      end
      `EXE_BEQ_OP:   br_take = (a == b);
      `EXE_BNE_OP:   br_take = (a != b);
      `EXE_BLT_OP:   br_take = ($signed(a) < $signed(b));
      `EXE_BGE_OP:   br_take = ($signed(a) >= $signed(b));
      `EXE_BLTU_OP:  br_take = (a < b);
      `EXE_BGEU_OP:  br_take = (a >= b);
      `EXE_LB_OP, `EXE_LH_OP, `EXE_LW_OP, `EXE_LBU_OP, `EXE_LHU_OP,
      `EXE_SB_OP, `EXE_SH_OP, `EXE_SW_OP: is_mem = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    case (bus.alusel_i)
      `EXE_RES_LOGIC: sc_res = logic_res;
      `EXE_RES_SHIFT: sc_res = shift_res;
      `EXE_RES_ARITH: sc_res = arith_res;
      `EXE_RES_JUMP:  sc_res = pc_4;
      default:        sc_res = '0;
    endcase
  end

`ifdef MULDIV_EN
  typedef enum logic [1:0] {IDLE, BUSY, DONE} md_state_t;
  md_state_t   state;
  logic [4:0]  cnt;
  logic [2:0]  md_op;
  logic        neg_a, neg_b, sgn_a, sgn_b, sa, sb;
  logic [31:0] hi, lo, opnd, res, mag_a, mag_b;
  logic [31:0] step_hi, step_lo, diff, fin;
  logic [32:0] acc, rem_sh;
  logic [63:0] prod;

  assign sgn_a = (op[2:0] inside {3'd1, 3'd2, 3'd4, 3'd6});
  assign sgn_b = (op[2:0] inside {3'd1, 3'd4, 3'd6});
  assign sa    = sgn_a & a[31];
  assign sb    = sgn_b & b[31];
  assign mag_a = sa ? -a : a;
  assign mag_b = sb ? -b : b;

  // hi:lo is the product for multiplies, remainder:quotient for divides, both on magnitudes
  always_comb begin
    acc    = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : 33'd0);
    rem_sh = {hi, lo[31]};
    diff   = rem_sh[31:0] - opnd;
    if (md_op[2]) begin
      if (rem_sh >= {1'b0, opnd}) begin
        step_hi = diff;
        step_lo = {lo[30:0], 1'b1};
      end else begin
        step_hi = rem_sh[31:0];
        step_lo = {lo[30:0], 1'b0};
      end
    end else begin
      step_hi = acc[32:1];
      step_lo = {acc[0], lo[31:1]};
    end
  end

  // A zero divisor leaves quotient all-ones and remainder = dividend, so the quotient is never negated then
  always_comb begin
    prod = {step_hi, step_lo};
    if (neg_a ^ neg_b) prod = -prod;
    case (md_op)
      3'd0:             fin = prod[31:0];
      3'd1, 3'd2, 3'd3: fin = prod[63:32];
      3'd4, 3'd5:       fin = ((neg_a ^ neg_b) && (opnd != 32'd0)) ? -step_lo : step_lo;
      default:          fin = neg_a ? -step_hi : step_hi;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
      md_op <= '0;
      neg_a <= 1'b0;
      neg_b <= 1'b0;
      hi    <= '0;
      lo    <= '0;
      opnd  <= '0;
      res   <= '0;
    end else begin
      case (state)
        IDLE: if (is_mop) begin
          state <= BUSY;
          cnt   <= '0;
          md_op <= op[2:0];
          neg_a <= sa;
          neg_b <= sb;
          hi    <= '0;
          lo    <= op[2] ? mag_a : mag_b;
          opnd  <= op[2] ? mag_b : mag_a;
        end
        BUSY: begin
          hi  <= step_hi;
          lo  <= step_lo;
          cnt <= cnt + 5'd1;
          if (cnt == 5'd31) begin
            state <= DONE;
            res   <= fin;
          end
        end
        DONE: if (bus.stall[3] == `NoStop) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign md_stall = ((state == IDLE) && is_mop) || (state == BUSY);
  assign md_done  = (state == DONE);
  assign md_res   = res;
`else
  logic unused_clk;
  assign unused_clk = clk;
  assign md_stall   = 1'b0;
  assign md_done    = 1'b0;
  assign md_res     = '0;
`endif

  always_comb begin
    wdata = sc_res;
    wreg  = bus.wreg_i && (bus.alusel_i != `EXE_RES_BRANCH);
    if (md_done) begin
      wdata = md_res;
      wreg  = bus.wreg_i;
    end else if (is_mop) begin
      wdata = '0;
      wreg  = 1'b0;
    end
  end

  assign br = !is_mop && !md_stall && !md_done && (br_take || is_jump);

  assign bus.wd_o            = rst ? bus.wd_i : 5'd0;
  assign bus.wreg_o          = rst & wreg;
  assign bus.wdata_o         = rst ? wdata : 32'd0;
  assign bus.aluop_o         = rst ? op : `Inst_NOP;
  assign bus.mem_addr_o      = (rst && is_mem) ? a_imm : 32'd0;
  assign bus.reg2_o          = rst ? b : 32'd0;
  assign bus.branch_flag_o   = rst & br;
  assign bus.branch_target_o = (rst && br) ? target : 32'd0;
  assign bus.exflush_o       = rst & br;
  assign bus.stallreq_o      = rst & md_stall;

endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: randomized and directed checks of ex_stage against an arithmetic reference model.
module tb_ex_stage;

  localparam logic [7:0] OP_NOP = 8'h00, OP_ADD = 8'h01, OP_SUB = 8'h02, OP_SLL = 8'h03,
    OP_SLT = 8'h04, OP_SLTU = 8'h05, OP_XOR = 8'h06, OP_SRL = 8'h07, OP_SRA = 8'h08,
    OP_OR = 8'h09, OP_AND = 8'h0A, OP_LUI = 8'h0B, OP_AUIPC = 8'h0C, OP_JAL = 8'h10,
    OP_JALR = 8'h11, OP_BEQ = 8'h12, OP_BNE = 8'h13, OP_BLT = 8'h14, OP_BGE = 8'h15,
    OP_BLTU = 8'h16, OP_BGEU = 8'h17, OP_LW = 8'h22, OP_SW = 8'h2A,
    OP_MUL = 8'h30, OP_MULH = 8'h31, OP_MULHSU = 8'h32, OP_MULHU = 8'h33,
    OP_DIV = 8'h34, OP_DIVU = 8'h35, OP_REM = 8'h36, OP_REMU = 8'h37;
  localparam logic [7:0] SC_OPS [22] = '{OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR,
    OP_SRL, OP_SRA, OP_OR, OP_AND, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BEQ, OP_BNE,
    OP_BLT, OP_BGE, OP_BLTU, OP_BGEU, OP_LW, OP_SW};
  localparam logic [7:0] M_OPS [8] = '{OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU,
    OP_DIV, OP_DIVU, OP_REM, OP_REMU};

  typedef struct {
    logic [31:0] wdata;
    logic        wreg;
    logic        br;
    logic [31:0] tgt;
    logic [31:0] maddr;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  ex_stage_if bus();
  ex_stage dut (.clk(clk), .rst(rst), .bus(bus.slave));

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [2:0] sel_of(input logic [7:0] op);
    case (op)
      OP_AND, OP_OR, OP_XOR:                                return 3'd1;
      OP_SLL, OP_SRL, OP_SRA:                               return 3'd2;
      OP_ADD, OP_SUB, OP_SLT, OP_SLTU, OP_LUI, OP_AUIPC:    return 3'd3;
      OP_JAL, OP_JALR:                                      return 3'd4;
      OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU:     return 3'd5;
      OP_LW, OP_SW:                                         return 3'd6;
      OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU,
      OP_DIV, OP_DIVU, OP_REM, OP_REMU:                     return 3'd7;
      default:                                              return 3'd0;
    endcase
  endfunction

  // Single-cycle behaviour; M ops here describe the non-completing (stalling or disabled) view
  function automatic exp_t ref_model(input logic [7:0] op, input logic [31:0] pc, r1, r2, imm,
                                     input logic we);
    exp_t e;
    e.wdata = '0; e.wreg = we; e.br = 1'b0; e.tgt = '0; e.maddr = '0;
    case (op)
      OP_ADD:   e.wdata = r1 + r2;
      OP_SUB:   e.wdata = r1 - r2;
      OP_SLL:   e.wdata = r1 << r2[4:0];
      OP_SRL:   e.wdata = r1 >> r2[4:0];
      OP_SRA:   e.wdata = $signed(r1) >>> r2[4:0];
      OP_SLT:   e.wdata = ($signed(r1) < $signed(r2)) ? 32'd1 : 32'd0;
      OP_SLTU:  e.wdata = (r1 < r2) ? 32'd1 : 32'd0;
      OP_XOR:   e.wdata = r1 ^ r2;
      OP_OR:    e.wdata = r1 | r2;
      OP_AND:   e.wdata = r1 & r2;
      OP_LUI:   e.wdata = imm;
      OP_AUIPC: e.wdata = pc + imm;
      OP_JAL:   begin e.wdata = pc + 32'd4; e.br = 1'b1; e.tgt = pc + imm; end
      OP_JALR:  begin e.wdata = pc + 32'd4; e.br = 1'b1; e.tgt = (r1 + imm) & 32'hFFFF_FFFE; end
      OP_BEQ:   e.br = (r1 == r2);
      OP_BNE:   e.br = (r1 != r2);
      OP_BLT:   e.br = ($signed(r1) < $signed(r2));
      OP_BGE:   e.br = ($signed(r1) >= $signed(r2));
      OP_BLTU:  e.br = (r1 < r2);
      OP_BGEU:  e.br = (r1 >= r2);
      OP_LW, OP_SW: e.maddr = r1 + imm;
      OP_NOP:   ;
      default:  e.wreg = 1'b0;
    endcase
    if (sel_of(op) == 3'd5) begin
      e.wreg = 1'b0;
      if (e.br) e.tgt = pc + imm;
    end
    return e;
  endfunction

  function automatic logic [31:0] m_ref(input logic [7:0] op, input logic [31:0] x, y);
    longint sx, sy, ux, uy;
    logic [63:0] p;
    sx = longint'($signed(x)); sy = longint'($signed(y));
    ux = longint'({32'd0, x}); uy = longint'({32'd0, y});
    p = '0;
    case (op)
      OP_MUL:    p = ux * uy;
      OP_MULH:   p = {(sx * sy) >>> 32};
      OP_MULHSU: p = {(sx * uy) >>> 32};
      OP_MULHU:  p = {32'd0, 64'(ux * uy) >> 32};
      OP_DIV:    p = (y == 0) ? 64'hFFFF_FFFF : sx / sy;
      OP_DIVU:   p = (y == 0) ? 64'hFFFF_FFFF : ux / uy;
      OP_REM:    p = (y == 0) ? ux : sx % sy;
      OP_REMU:   p = (y == 0) ? ux : ux % uy;
      default:   p = '0;
    endcase
    return p[31:0];
  endfunction

  task automatic drive(input logic [7:0] op, input logic [31:0] pc, r1, r2, imm,
                       input logic [4:0] wd, input logic we);
    bus.aluop_i  = op;
    bus.alusel_i = sel_of(op);
    bus.pc_i     = pc;
    bus.reg1_i   = r1;
    bus.reg2_i   = r2;
    bus.imm_i    = imm;
    bus.wd_i     = wd;
    bus.wreg_i   = we;
  endtask

  task automatic exec_sc(input string tag, input logic [7:0] op, input logic [31:0] pc, r1, r2,
                         imm, input logic [4:0] wd, input logic we);
    exp_t e;
    @(negedge clk);
    drive(op, pc, r1, r2, imm, wd, we);
    #2;
    e = ref_model(op, pc, r1, r2, imm, we);
    check_eq({tag, ".wdata"},  bus.wdata_o,         e.wdata);
    check_eq({tag, ".wreg"},   bus.wreg_o,          e.wreg);
    check_eq({tag, ".br"},     bus.branch_flag_o,   e.br);
    check_eq({tag, ".tgt"},    bus.branch_target_o, e.tgt);
    check_eq({tag, ".flush"},  bus.exflush_o,       e.br);
    check_eq({tag, ".maddr"},  bus.mem_addr_o,      e.maddr);
    check_eq({tag, ".stall"},  bus.stallreq_o,      1'b0);
    check_eq({tag, ".wd"},     bus.wd_o,            wd);
    check_eq({tag, ".aluop"},  bus.aluop_o,         op);
    check_eq({tag, ".reg2"},   bus.reg2_o,          r2);
  endtask

  task automatic run_mop(input string tag, input logic [7:0] op, input logic [31:0] x, y,
                         input int hold);
    logic [31:0] exp_v;
    int n;
    exp_v = m_ref(op, x, y);
    @(negedge clk);
    drive(op, 32'h40, x, y, 32'd0, 5'd9, 1'b1);
    bus.stall = 6'b000000;
    #2;
    check_eq({tag, ".nobr"}, bus.branch_flag_o, 1'b0);
    n = 0;
    while (bus.stallreq_o === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
      bus.reg1_i = $urandom;
      bus.reg2_i = $urandom;
      #2;
    end
    check_eq({tag, ".stall_cycles"}, n, 33);
    for (int i = 0; i <= hold; i++) begin
      bus.stall = (i < hold) ? 6'b001000 : 6'b000000;
      check_eq({tag, ".wdata"}, bus.wdata_o, exp_v);
      check_eq({tag, ".wreg"},  bus.wreg_o, 1'b1);
      check_eq({tag, ".done_stall"}, bus.stallreq_o, 1'b0);
      @(negedge clk);
      #2;
    end
    drive(OP_NOP, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0);
    #1;
    check_eq({tag, ".idle_wdata"}, bus.wdata_o, 32'd0);
    check_eq({tag, ".idle_stall"}, bus.stallreq_o, 1'b0);
  endtask

  initial begin
    logic [31:0] r1, r2;
    bus.stall = 6'b000000;
    drive(OP_ADD, 32'h1234, 32'hDEAD_BEEF, 32'h5, 32'h44, 5'd7, 1'b1);
    #12;
    check_eq("rst.wd",    bus.wd_o, 5'd0);
    check_eq("rst.wreg",  bus.wreg_o, 1'b0);
    check_eq("rst.wdata", bus.wdata_o, 32'd0);
    check_eq("rst.aluop", bus.aluop_o, OP_NOP);
    check_eq("rst.reg2",  bus.reg2_o, 32'd0);
    drive(OP_DIV, 32'h1234, 32'h9, 32'h3, 32'h44, 5'd7, 1'b1);
    #1;
    check_eq("rst.stall", bus.stallreq_o, 1'b0);
    drive(OP_NOP, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0);
    @(negedge clk);
    rst = 1'b1;

    exec_sc("add_wrap", OP_ADD, 32'h0, 32'hFFFF_FFFF, 32'd1, 32'd0, 5'd1, 1'b1);
    check_eq("add_wrap.lit", bus.wdata_o, 32'h0);
    exec_sc("blt", OP_BLT, 32'h100, 32'hFFFF_FFFE, 32'd1, 32'h20, 5'd0, 1'b0);
    check_eq("blt.lit_tgt", bus.branch_target_o, 32'h120);
    exec_sc("bltu", OP_BLTU, 32'h100, 32'hFFFF_FFFE, 32'd1, 32'h20, 5'd0, 1'b0);
    check_eq("bltu.lit_br", bus.branch_flag_o, 1'b0);
    exec_sc("jalr", OP_JALR, 32'h200, 32'h1001, 32'd0, 32'd0, 5'd1, 1'b1);
    check_eq("jalr.lit_tgt", bus.branch_target_o, 32'h1000);
    check_eq("jalr.lit_wd", bus.wdata_o, 32'h204);
    exec_sc("nop", OP_NOP, 32'h300, 32'h55, 32'h66, 32'h77, 5'd0, 1'b0);

    for (int i = 0; i < 300; i++) begin
      r1 = $urandom;
      case ($urandom_range(0, 3))
        0:       r2 = r1;
        1:       r2 = $urandom_range(0, 40);
        default: r2 = $urandom;
      endcase
      exec_sc("rand", SC_OPS[$urandom_range(0, 21)], $urandom, r1, r2, $urandom,
              5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
    end

`ifdef MULDIV_EN
    run_mop("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_mop("remu_z",  OP_REMU, 32'd7, 32'd0, 0);
    run_mop("mulhu",   OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2);
    run_mop("div_z",   OP_DIV, 32'hFFFF_FFF9, 32'd0, 0);
    run_mop("rem_neg", OP_REM, 32'hFFFF_FFF9, 32'd2, 1);
    for (int i = 0; i < 8; i++) begin
      r2 = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 9)) : $urandom;
      run_mop("mrand", M_OPS[i], $urandom, r2, $urandom_range(0, 2));
    end

    @(negedge clk);
    drive(OP_DIV, 32'h40, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 5'd9, 1'b1);
    repeat (11) @(negedge clk);
    #2;
    check_eq("rst_mid.busy", bus.stallreq_o, 1'b1);
    rst = 1'b0;
    #1;
    check_eq("rst_mid.stall", bus.stallreq_o, 1'b0);
    check_eq("rst_mid.wdata", bus.wdata_o, 32'd0);
    check_eq("rst_mid.wreg",  bus.wreg_o, 1'b0);
    check_eq("rst_mid.wd",    bus.wd_o, 5'd0);
    drive(OP_NOP, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    run_mop("div_rerun", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0);
`else
    for (int i = 0; i < 8; i++)
      exec_sc("m_nop", M_OPS[i], $urandom, $urandom, $urandom, $urandom, 5'd4, 1'b1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
